// File: rtl/neuron_param_pkg.sv
// Shared definitions for the neuron parameter bank: word offsets, field byte
// positions, widths and the registered core-side field bundle.
package neuron_param_pkg;

  localparam int FIELD_W = 8;
  localparam int CNT_W   = 16;

  localparam logic [1:0] W_RESET  = 2'd0;
  localparam logic [1:0] W_WEIGHT = 2'd1;
  localparam logic [1:0] W_STATE  = 2'd2;
  localparam logic [1:0] W_STATUS = 2'd3;

  localparam int POS_RESET_LSB = 24;
  localparam int NEG_RESET_LSB = 16;
  localparam int WEIGHT1_LSB   = 24;
  localparam int WEIGHT2_LSB   = 16;
  localparam int WEIGHT3_LSB   = 8;
  localparam int WEIGHT4_LSB   = 0;
  localparam int VP_LSB        = 24;
  localparam int POS_TH_LSB    = 16;
  localparam int NEG_TH_LSB    = 8;
  localparam int LEAK_LSB      = 0;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] vp;
    logic [FIELD_W-1:0] pos_th;
    logic [FIELD_W-1:0] neg_th;
    logic [FIELD_W-1:0] leak;
    logic [FIELD_W-1:0] weight1;
    logic [FIELD_W-1:0] weight2;
    logic [FIELD_W-1:0] weight3;
    logic [FIELD_W-1:0] weight4;
    logic [FIELD_W-1:0] pos_reset;
    logic [FIELD_W-1:0] neg_reset;
  } neuron_fields_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      else        res[b*8 +: 8] = old_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_param_entry.sv
// Storage for one neuron: reset, weight and state words plus a saturating
// write-back counter. Wishbone bytes apply first, then the core write-back.
module neuron_param_entry
  import neuron_param_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [1:0]         wr_word_i,
  input  logic [3:0]         wr_sel_i,
  input  logic [31:0]        wr_dat_i,
  input  logic               vp_wr_en_i,
  input  logic [FIELD_W-1:0] vp_i,
  output logic [31:0]        reset_word_o,
  output logic [31:0]        weight_word_o,
  output logic [31:0]        state_word_o,
  output logic [31:0]        status_word_o
);

  logic [15:0]      reset_q, reset_d;
  logic [31:0]      weight_q, weight_d;
  logic [31:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_base_s;
  logic [31:0]      reset_merged_s;

  // Next-state for all words; a status clear lands before the increment.
  always_comb begin
    reset_d        = reset_q;
    weight_d       = weight_q;
    state_d        = state_q;
    cnt_base_s     = cnt_q;
    reset_merged_s = {reset_q, 16'h0000};
    if (wr_en_i) begin
      case (wr_word_i)
        W_RESET: begin
          reset_merged_s = byte_merge({reset_q, 16'h0000}, wr_dat_i, {wr_sel_i[3:2], 2'b00});
          reset_d        = reset_merged_s[31:16];
        end
        W_WEIGHT: weight_d = byte_merge(weight_q, wr_dat_i, wr_sel_i);
        W_STATE:  state_d  = byte_merge(state_q, wr_dat_i, wr_sel_i);
        W_STATUS: begin
          if (|wr_sel_i) cnt_base_s = {CNT_W{1'b0}};
          else           cnt_base_s = cnt_q;
        end
        default: cnt_base_s = cnt_q;
      endcase
    end else begin
      cnt_base_s = cnt_q;
    end
    if (vp_wr_en_i) begin
      state_d[VP_LSB +: FIELD_W] = vp_i;
      if (cnt_base_s == {CNT_W{1'b1}}) cnt_d = cnt_base_s;
      else                             cnt_d = cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_base_s;
    end
  end

  // Storage registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reset_q  <= 16'h0000;
      weight_q <= 32'h0000_0000;
      state_q  <= 32'h0000_0000;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      reset_q  <= reset_d;
      weight_q <= weight_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign reset_word_o  = {reset_q, 16'h0000};
  assign weight_word_o = weight_q;
  assign state_word_o  = state_q;
  assign status_word_o = {16'h0000, cnt_q};

endmodule

// File: rtl/neuron_param_bank.sv
// Wishbone-mapped parameter store for NUM_NEURONS neurons with a registered
// core-side read port and a voltage write-back port.
module neuron_param_bank
  import neuron_param_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_1000,
  parameter int          NUM_NEURONS = 4,
  localparam int         IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               core_rd_en_i,
  input  logic [IDX_W-1:0]   core_rd_idx_i,
  output logic               core_valid_o,
  input  logic               core_wr_en_i,
  input  logic [IDX_W-1:0]   core_wr_idx_i,
  input  logic [FIELD_W-1:0] core_vp_i,
  output logic [FIELD_W-1:0] voltage_potential_o,
  output logic [FIELD_W-1:0] pos_threshold_o,
  output logic [FIELD_W-1:0] neg_threshold_o,
  output logic [FIELD_W-1:0] leak_value_o,
  output logic [FIELD_W-1:0] weight_type1_o,
  output logic [FIELD_W-1:0] weight_type2_o,
  output logic [FIELD_W-1:0] weight_type3_o,
  output logic [FIELD_W-1:0] weight_type4_o,
  output logic [FIELD_W-1:0] pos_reset_o,
  output logic [FIELD_W-1:0] neg_reset_o
);

  localparam logic [31:0] SPAN = 32'(NUM_NEURONS * 16);

  wb_state_e      state_q, state_d;
  logic [31:0]    dat_q, dat_d;
  logic           valid_q, valid_d;
  neuron_fields_t fields_q, fields_d;

  logic [31:0]      offset_s;
  logic             in_range_s;
  logic             access_s;
  logic [IDX_W-1:0] wb_idx_s;
  logic [1:0]       wb_word_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      core_reset_s, core_weight_s, core_state_s;

  logic [31:0] reset_w_s  [NUM_NEURONS];
  logic [31:0] weight_w_s [NUM_NEURONS];
  logic [31:0] state_w_s  [NUM_NEURONS];
  logic [31:0] status_w_s [NUM_NEURONS];

  assign offset_s   = wbs_adr_i - BASE_ADDR;
  assign in_range_s = (wbs_adr_i >= BASE_ADDR) && (offset_s < SPAN);
  assign wb_idx_s   = offset_s[IDX_W+3:4];
  assign wb_word_s  = offset_s[3:2];
  assign access_s   = wbs_cyc_i && wbs_stb_i && (state_q == WB_IDLE);

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_entry
    neuron_param_entry u_entry (
      .clk_i         (wb_clk_i),
      .rst_i         (wb_rst_i),
      .wr_en_i       (access_s && wbs_we_i && in_range_s && (wb_idx_s == IDX_W'(gi))),
      .wr_word_i     (wb_word_s),
      .wr_sel_i      (wbs_sel_i),
      .wr_dat_i      (wbs_dat_i),
      .vp_wr_en_i    (core_wr_en_i && (core_wr_idx_i == IDX_W'(gi))),
      .vp_i          (core_vp_i),
      .reset_word_o  (reset_w_s[gi]),
      .weight_word_o (weight_w_s[gi]),
      .state_word_o  (state_w_s[gi]),
      .status_word_o (status_w_s[gi])
    );
  end

  // Wishbone read mux; out-of-range accesses read as zero.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if (in_range_s) begin
      case (wb_word_s)
        W_RESET:  rd_word_s = reset_w_s[wb_idx_s];
        W_WEIGHT: rd_word_s = weight_w_s[wb_idx_s];
        W_STATE:  rd_word_s = state_w_s[wb_idx_s];
        W_STATUS: rd_word_s = status_w_s[wb_idx_s];
        default:  rd_word_s = 32'h0000_0000;
      endcase
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Ack FSM: one access per idle cycle, ack forced low the cycle after.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    case (state_q)
      WB_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d = WB_ACK;
          if (!wbs_we_i) dat_d = rd_word_s;
          else           dat_d = dat_q;
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_ACK:  state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  assign core_reset_s  = reset_w_s[core_rd_idx_i];
  assign core_weight_s = weight_w_s[core_rd_idx_i];
  assign core_state_s  = state_w_s[core_rd_idx_i];

  // Core read captures the pre-write fields of the selected neuron.
  always_comb begin
    fields_d = fields_q;
    valid_d  = core_rd_en_i;
    if (core_rd_en_i) begin
      fields_d.vp        = core_state_s[VP_LSB +: FIELD_W];
      fields_d.pos_th    = core_state_s[POS_TH_LSB +: FIELD_W];
      fields_d.neg_th    = core_state_s[NEG_TH_LSB +: FIELD_W];
      fields_d.leak      = core_state_s[LEAK_LSB +: FIELD_W];
      fields_d.weight1   = core_weight_s[WEIGHT1_LSB +: FIELD_W];
      fields_d.weight2   = core_weight_s[WEIGHT2_LSB +: FIELD_W];
      fields_d.weight3   = core_weight_s[WEIGHT3_LSB +: FIELD_W];
      fields_d.weight4   = core_weight_s[WEIGHT4_LSB +: FIELD_W];
      fields_d.pos_reset = core_reset_s[POS_RESET_LSB +: FIELD_W];
      fields_d.neg_reset = core_reset_s[NEG_RESET_LSB +: FIELD_W];
    end else begin
      fields_d = fields_q;
    end
  end

  // Output and handshake registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= WB_IDLE;
      dat_q    <= 32'h0000_0000;
      valid_q  <= 1'b0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      dat_q    <= dat_d;
      valid_q  <= valid_d;
      fields_q <= fields_d;
    end
  end

  assign wbs_ack_o           = (state_q == WB_ACK);
  assign wbs_dat_o           = dat_q;
  assign core_valid_o        = valid_q;
  assign voltage_potential_o = fields_q.vp;
  assign pos_threshold_o     = fields_q.pos_th;
  assign neg_threshold_o     = fields_q.neg_th;
  assign leak_value_o        = fields_q.leak;
  assign weight_type1_o      = fields_q.weight1;
  assign weight_type2_o      = fields_q.weight2;
  assign weight_type3_o      = fields_q.weight3;
  assign weight_type4_o      = fields_q.weight4;
  assign pos_reset_o         = fields_q.pos_reset;
  assign neg_reset_o         = fields_q.neg_reset;

endmodule

// File: tb/tb_neuron_param_bank.sv
// Scoreboard bench for neuron_param_bank: a driver updates a word-level
// reference model and queues expectations; a monitor checks DUT responses.
module tb_neuron_param_bank;

  localparam logic [31:0] BASE = 32'h3000_1000;
  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        crd = 1'b0, cwr = 1'b0;
  logic [1:0]  crd_idx = 2'd0, cwr_idx = 2'd0;
  logic [7:0]  cvp = 8'h00;
  logic        cvalid;
  logic [7:0]  o_vp, o_pth, o_nth, o_leak, o_w1, o_w2, o_w3, o_w4, o_pr, o_nr;

  neuron_param_bank #(.BASE_ADDR(BASE), .NUM_NEURONS(NN)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .core_rd_en_i(crd), .core_rd_idx_i(crd_idx), .core_valid_o(cvalid),
    .core_wr_en_i(cwr), .core_wr_idx_i(cwr_idx), .core_vp_i(cvp),
    .voltage_potential_o(o_vp), .pos_threshold_o(o_pth), .neg_threshold_o(o_nth),
    .leak_value_o(o_leak), .weight_type1_o(o_w1), .weight_type2_o(o_w2),
    .weight_type3_o(o_w3), .weight_type4_o(o_w4), .pos_reset_o(o_pr), .neg_reset_o(o_nr)
  );

  always #5 clk = ~clk;

  // Reference model: plain words per neuron plus an integer counter.
  bit [31:0] m_w0 [NN];
  bit [31:0] m_w1 [NN];
  bit [31:0] m_w2 [NN];
  int        m_cnt [NN];
  bit        m_ack = 1'b0;

  typedef struct { bit chk; bit [31:0] dat; } wb_exp_t;
  bit        ack_exp_q [$];
  wb_exp_t   wb_exp_q [$];
  bit [79:0] core_exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_in_range(input bit [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(NN * 16));
  endfunction

  function automatic bit [31:0] m_read(input bit [31:0] a);
    bit [31:0] off;
    int n, w;
    if (!m_in_range(a)) return 32'h0;
    off = a - BASE;
    n = int'(off >> 4);
    w = int'((off >> 2) & 32'd3);
    case (w)
      0:       return m_w0[n] & 32'hFFFF_0000;
      1:       return m_w1[n];
      2:       return m_w2[n];
      default: return 32'(m_cnt[n]);
    endcase
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] d, input bit [3:0] s);
    bit [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic m_write(input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
    bit [31:0] off;
    int n, w;
    if (!m_in_range(a)) return;
    off = a - BASE;
    n = int'(off >> 4);
    w = int'((off >> 2) & 32'd3);
    case (w)
      0:       m_w0[n] = merge(m_w0[n], d, s) & 32'hFFFF_0000;
      1:       m_w1[n] = merge(m_w1[n], d, s);
      2:       m_w2[n] = merge(m_w2[n], d, s);
      default: if (s != 4'h0) m_cnt[n] = 0;
    endcase
  endtask

  // One clock of stimulus; expectations are taken before the model updates.
  task automatic do_cycle(input bit go, input bit w, input bit [31:0] a, input bit [31:0] d,
                          input bit [3:0] s, input bit rd, input bit [1:0] ri,
                          input bit wr, input bit [1:0] wi, input bit [7:0] vp);
    bit exec;
    wb_exp_t e;
    @(negedge clk);
    cyc = go; stb = go; we = w; adr = a; wdat = d; sel = s;
    crd = rd; crd_idx = ri; cwr = wr; cwr_idx = wi; cvp = vp;
    exec = go && !m_ack;
    if (rd) core_exp_q.push_back({m_w2[ri], m_w1[ri], m_w0[ri][31:16]});
    if (exec) begin
      e.chk = !w;
      e.dat = m_read(a);
      wb_exp_q.push_back(e);
      if (w) m_write(a, d, s);
    end
    if (wr) begin
      m_w2[wi][31:24] = vp;
      if (m_cnt[wi] < 65535) m_cnt[wi]++;
    end
    m_ack = exec;
    ack_exp_q.push_back(exec);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic wb(input bit w, input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
    do_cycle(1'b1, w, a, d, s, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
    idle();
  endtask

  task automatic core_rd(input bit [1:0] i);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, i, 1'b0, 2'd0, 8'h00);
    idle();
  endtask

  function automatic bit [31:0] rand_adr();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 16)       return BASE + 32'(r * 4);
    else if (r < 18)  return BASE + 32'h40 + 32'($urandom_range(0, 15) * 4);
    else if (r == 18) return BASE - 32'd4;
    else              return BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
  endfunction

  // Monitor: checks ack every driven cycle, read data on ack, fields on valid.
  wb_exp_t   mon_e;
  bit        mon_ack;
  bit [79:0] mon_core;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (ack_exp_q.size() > 0) begin
        mon_ack = ack_exp_q.pop_front();
        check("wb_ack", {79'd0, ack}, {79'd0, mon_ack});
      end
      if (ack === 1'b1) begin
        if (wb_exp_q.size() == 0) begin
          check("wb_spurious_ack", 80'd1, 80'd0);
        end else begin
          mon_e = wb_exp_q.pop_front();
          if (mon_e.chk) check("wb_rdata", {48'd0, rdat}, {48'd0, mon_e.dat});
        end
      end
      if (cvalid === 1'b1) begin
        if (core_exp_q.size() == 0) begin
          check("core_spurious_valid", 80'd1, 80'd0);
        end else begin
          mon_core = core_exp_q.pop_front();
          check("core_fields", {o_vp, o_pth, o_nth, o_leak, o_w1, o_w2, o_w3, o_w4, o_pr, o_nr},
                mon_core);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NN; i++) begin
      m_w0[i] = 32'h0; m_w1[i] = 32'h0; m_w2[i] = 32'h0; m_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", {79'd0, ack}, 80'd0);
    check("rst_dat", {48'd0, rdat}, 80'd0);
    check("rst_valid", {79'd0, cvalid}, 80'd0);
    check("rst_fields", {o_vp, o_pth, o_nth, o_leak, o_w1, o_w2, o_w3, o_w4, o_pr, o_nr}, 80'd0);
    mon_en = 1'b1;

    // Basic read, write then core read, reserved bits.
    wb(1'b0, BASE + 32'h18, 32'h0, 4'h0);
    wb(1'b1, BASE + 32'h18, 32'hAA55_3311, 4'hF);
    core_rd(2'd1);
    wb(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1100);
    wb(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    core_rd(2'd1);

    // Same-cycle Wishbone write and core write-back to neuron 2.
    do_cycle(1'b1, 1'b1, BASE + 32'h28, 32'h0102_0304, 4'hF, 1'b0, 2'd0, 1'b1, 2'd2, 8'h7F);
    idle();
    wb(1'b0, BASE + 32'h28, 32'h0, 4'h0);
    wb(1'b0, BASE + 32'h2C, 32'h0, 4'h0);

    // Core read and write to the same index return the old potential.
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 2'd2, 1'b1, 2'd2, 8'h33);
    idle();
    core_rd(2'd2);

    // Counter saturation, then clear alongside an increment.
    for (int i = 0; i < 65536; i++)
      do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 8'(i));
    wb(1'b0, BASE + 32'h0C, 32'h0, 4'h0);
    do_cycle(1'b1, 1'b1, BASE + 32'h0C, 32'h0, 4'hF, 1'b0, 2'd0, 1'b1, 2'd0, 8'h44);
    idle();
    wb(1'b0, BASE + 32'h0C, 32'h0, 4'h0);

    // Out of range accesses.
    wb(1'b0, BASE + 32'h40, 32'h0, 4'h0);
    wb(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
    wb(1'b1, BASE - 32'd4, 32'hFFFF_FFFF, 4'hF);
    wb(1'b0, BASE - 32'd4, 32'h0, 4'h0);

    // Strobe held high for five cycles: ack 1,0,1,0,1.
    for (int i = 0; i < 5; i++)
      do_cycle(1'b1, 1'b0, BASE + 32'h18, 32'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
    idle();

    // Randomized mixed traffic.
    for (int i = 0; i < 600; i++)
      do_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rand_adr(), $urandom(),
               4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    idle();

    // Final sweep of every word and every neuron.
    for (int i = 0; i < NN * 4; i++) wb(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0);
    for (int i = 0; i < NN; i++) core_rd(2'(i));

    repeat (3) @(negedge clk);
    check("wb_pending", 80'(wb_exp_q.size()), 80'd0);
    check("core_pending", 80'(core_exp_q.size()), 80'd0);
    check("ack_pending", 80'(ack_exp_q.size()), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
